// File: rtl/vector_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vector_alu_pkg
//  Purpose  : Shared types and helpers for the pipelined vector ALU.
//             - op_e  : 2-bit operation encoding (ADD/SUB/MUL/MAC)
//             - lanes : number of ELEN-bit lanes in a VLEN-bit vector
//  Revision : 1.0  initial release
// ============================================================================
package vector_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    function automatic int lanes(input int vlen, input int elen);
        return vlen / elen;
    endfunction

endpackage : vector_alu_pkg
`default_nettype wire

// File: rtl/vector_alu_lane.sv
`default_nettype none
// ============================================================================
//  Module   : vector_alu_lane
//  Purpose  : Datapath of one unsigned ELEN-bit lane of the vector ALU, with
//             its private 2*ELEN-bit MAC accumulator. Produces the 2*ELEN-bit
//             lane result combinationally at the input of the output register
//             that lives in the top level.
//  Ports    : clk      clock, rising edge
//             rst      synchronous active-high reset (accumulator only)
//             i_adv    pipeline advances this cycle (not stalled)
//             i_upd    a valid beat leaves the final stage this cycle
//             i_op     operation of the beat entering stage 1
//             i_clr    accumulator clear flag of the beat entering stage 1
//             i_a/i_b  lane operands
//             o_res    2*ELEN-bit result of the beat in the final stage
//  Revision : 1.0  initial release
// ============================================================================
module vector_alu_lane
    import vector_alu_pkg::*;
#(
    parameter int ELEN = 32,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic              i_upd,
    input  op_e               i_op,
    input  logic              i_clr,
    input  logic [ELEN-1:0]   i_a,
    input  logic [ELEN-1:0]   i_b,
    output logic [2*ELEN-1:0] o_res
);

    localparam int c_W2  = 2 * ELEN;
    localparam int c_H   = ELEN / 2;
    localparam int c_PPW = ELEN + c_H;

    // ------------------------------------------------------------------
    // Stage 1: ADD/SUB resolved, multiplier split into two half-width
    // partial products (a * b_lo, a * b_hi) so the wide adder that merges
    // them sits in the next stage.
    // ------------------------------------------------------------------
    logic [ELEN:0]    w_sum;
    logic [ELEN:0]    w_dif;
    logic [ELEN:0]    w_x;
    logic [c_W2-1:0]  w_as;
    logic [c_PPW-1:0] w_pp_lo;
    logic [c_PPW-1:0] w_pp_hi;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    // Bit ELEN of the extended difference is set exactly when a < b.
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};
    assign w_x   = (i_op == OP_SUB) ? w_dif : w_sum;
    assign w_as  = {{(ELEN-1){1'b0}}, w_x[ELEN], w_x[ELEN-1:0]};

    assign w_pp_lo = c_PPW'(i_a) * c_PPW'(i_b[c_H-1:0]);
    assign w_pp_hi = c_PPW'(i_a) * c_PPW'(i_b[ELEN-1:c_H]);

    op_e              r_s1_op;
    logic             r_s1_clr;
    logic [c_W2-1:0]  r_s1_as;
    logic [c_PPW-1:0] r_s1_pplo;
    logic [c_PPW-1:0] r_s1_pphi;

    // Data registers carry no reset: bubbles are tagged by the shared valid
    // pipeline in the top level and never touch state.
    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_s1_op   <= i_op;
            r_s1_clr  <= i_clr;
            r_s1_as   <= w_as;
            r_s1_pplo <= w_pp_lo;
            r_s1_pphi <= w_pp_hi;
        end
    end

    logic [c_W2-1:0] w_s1_prod;
    logic [c_W2-1:0] w_s1_res;

    assign w_s1_prod = c_W2'(r_s1_pplo) + (c_W2'(r_s1_pphi) << c_H);
    assign w_s1_res  = ((r_s1_op == OP_MUL) || (r_s1_op == OP_MAC)) ? w_s1_prod : r_s1_as;

    // ------------------------------------------------------------------
    // Delay-match stages 2..LAT-1 so every op leaves after LAT cycles.
    // ------------------------------------------------------------------
    logic [c_W2-1:0] w_fin_res;
    op_e             w_fin_op;
    logic            w_fin_clr;

    if (LAT == 2) begin : g_lat2
        assign w_fin_res = w_s1_res;
        assign w_fin_op  = r_s1_op;
        assign w_fin_clr = r_s1_clr;
    end else begin : g_latn
        logic [c_W2-1:0] r_dres [LAT-2];
        op_e             r_dop  [LAT-2];
        logic            r_dclr [LAT-2];

        always_ff @(posedge clk) begin
            if (i_adv) begin
                r_dres[0] <= w_s1_res;
                r_dop[0]  <= r_s1_op;
                r_dclr[0] <= r_s1_clr;
                for (int k = 1; k < LAT - 2; k++) begin
                    r_dres[k] <= r_dres[k-1];
                    r_dop[k]  <= r_dop[k-1];
                    r_dclr[k] <= r_dclr[k-1];
                end
            end
        end

        assign w_fin_res = r_dres[LAT-3];
        assign w_fin_op  = r_dop[LAT-3];
        assign w_fin_clr = r_dclr[LAT-3];
    end

    // ------------------------------------------------------------------
    // Final stage: accumulator read-modify-write. The accumulator is
    // written in the same cycle the MAC beat enters the output register,
    // so a following MAC in the final stage already sees the new value.
    // ------------------------------------------------------------------
    logic [c_W2-1:0] r_acc;
    logic [c_W2-1:0] w_base;
    logic [c_W2-1:0] w_mac;

    always_comb begin
        w_base = w_fin_clr ? '0 : r_acc;
        w_mac  = w_base + w_fin_res;
        o_res  = (w_fin_op == OP_MAC) ? w_mac : w_fin_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_upd) begin
            if (w_fin_op == OP_MAC) begin
                r_acc <= w_mac;
            end else if (w_fin_clr) begin
                r_acc <= '0;
            end
        end
    end

endmodule : vector_alu_lane
`default_nettype wire

// File: rtl/vector_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : vector_alu_pipe
//  Purpose  : Pipelined vector ALU. Splits VLEN-bit operands into VLEN/ELEN
//             independent unsigned lanes performing ADD/SUB/MUL/MAC with a
//             fixed latency of LAT cycles and valid/ready handshakes on both
//             sides. Each lane yields a 2*ELEN result split into res_lo and
//             res_hi.
//  Ports    : clk, reset          clock / synchronous active-high reset
//             in_valid, in_ready  operand beat handshake
//             op, acc_clr, a, b   operation, accumulator clear, operands
//             out_valid,out_ready result beat handshake
//             res_lo, res_hi      per-lane low / high halves of the result
//  Revision : 1.0  initial release
// ============================================================================
module vector_alu_pipe
    import vector_alu_pkg::*;
#(
    parameter int VLEN = 512,
    parameter int ELEN = 32,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            acc_clr,
    input  logic [VLEN-1:0] a,
    input  logic [VLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] res_lo,
    output logic [VLEN-1:0] res_hi
);

    localparam int c_NLANES = lanes(VLEN, ELEN);

    // A stalled output freezes the whole pipe; otherwise everything,
    // including bubbles, moves one stage per cycle.
    logic w_stall;
    logic w_adv;
    logic w_upd;

    // r_vld[k] tags the beat held in internal stage k (1..LAT-1).
    logic [LAT-1:1] r_vld;

    assign w_stall  = out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = !w_stall;
    assign w_upd    = w_adv && r_vld[LAT-1];

    logic [VLEN-1:0] w_lo;
    logic [VLEN-1:0] w_hi;

    for (genvar g = 0; g < c_NLANES; g++) begin : g_lane
        logic [2*ELEN-1:0] w_res;

        vector_alu_lane #(
            .ELEN (ELEN),
            .LAT  (LAT)
        ) u_lane (
            .clk   (clk),
            .rst   (reset),
            .i_adv (w_adv),
            .i_upd (w_upd),
            .i_op  (op_e'(op)),
            .i_clr (acc_clr),
            .i_a   (a[g*ELEN +: ELEN]),
            .i_b   (b[g*ELEN +: ELEN]),
            .o_res (w_res)
        );

        assign w_lo[g*ELEN +: ELEN] = w_res[ELEN-1:0];
        assign w_hi[g*ELEN +: ELEN] = w_res[2*ELEN-1:ELEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= '0;
            out_valid <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
        end else if (w_adv) begin
            r_vld[1] <= in_valid;
            for (int k = 2; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            out_valid <= r_vld[LAT-1];
            // Results only load on a real beat so they keep their last value
            // across bubbles.
            if (r_vld[LAT-1]) begin
                res_lo <= w_lo;
                res_hi <= w_hi;
            end
        end
    end

endmodule : vector_alu_pipe
`default_nettype wire

// File: tb/tb_vector_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_alu_pipe
//  Purpose  : Self-checking bench for vector_alu_pipe. A reference model
//             computes expected lane results at accept time into a queue;
//             the monitor pops and compares at each consumed result.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_alu_pipe;
    import vector_alu_pkg::*;

    localparam int VLEN = 512;
    localparam int ELEN = 32;
    localparam int LAT  = 3;
    localparam int NL   = VLEN / ELEN;
    localparam int W2   = 2 * ELEN;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      op = 2'b00;
    logic            acc_clr = 1'b0;
    logic [VLEN-1:0] a = '0;
    logic [VLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [VLEN-1:0] res_lo;
    logic [VLEN-1:0] res_hi;

    vector_alu_pipe #(.VLEN(VLEN), .ELEN(ELEN), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VLEN-1:0] lo;
        logic [VLEN-1:0] hi;
        int              t;
    } exp_t;

    exp_t            sb[$];
    logic [VLEN-1:0] log_lo[$];
    logic [VLEN-1:0] log_hi[$];
    int              log_t[$];
    logic [W2-1:0]   macc [NL];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   win_lo = 0;
    int   win_hi = -1;
    int   stall_seen = 0;
    bit   lat_chk = 1'b0;
    bit   bp_chk = 1'b0;
    bit   prev_stall = 1'b0;
    logic [VLEN-1:0] prev_lo;
    logic [VLEN-1:0] prev_hi;

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rep(input logic [ELEN-1:0] v);
        logic [VLEN-1:0] r;
        for (int i = 0; i < NL; i++) r[i*ELEN +: ELEN] = v;
        return r;
    endfunction

    function automatic logic [VLEN-1:0] rnd_vec();
        logic [VLEN-1:0] r;
        for (int w = 0; w < VLEN / 32; w++) r[w*32 +: 32] = $urandom;
        if ($urandom_range(0, 7) == 0) r = '1;
        return r;
    endfunction

    // Reference model: per-lane unsigned arithmetic, updates model accumulators.
    function automatic void model(input logic [1:0] mop, input logic mclr,
                                  input logic [VLEN-1:0] ma, input logic [VLEN-1:0] mb,
                                  output logic [VLEN-1:0] lo, output logic [VLEN-1:0] hi);
        logic [ELEN-1:0] ai;
        logic [ELEN-1:0] bi;
        logic [W2-1:0]   full;
        lo = '0;
        hi = '0;
        for (int i = 0; i < NL; i++) begin
            ai   = ma[i*ELEN +: ELEN];
            bi   = mb[i*ELEN +: ELEN];
            full = '0;
            case (mop)
                2'b00: full = W2'(ai) + W2'(bi);
                2'b01: begin
                    full[ELEN-1:0]  = ai - bi;
                    full[W2-1:ELEN] = ELEN'(ai < bi);
                end
                2'b10: full = W2'(ai) * W2'(bi);
                default: begin
                    if (mclr) macc[i] = '0;
                    macc[i] = macc[i] + W2'(ai) * W2'(bi);
                    full    = macc[i];
                end
            endcase
            if (mop != 2'b11 && mclr) macc[i] = '0;
            lo[i*ELEN +: ELEN] = full[ELEN-1:0];
            hi[i*ELEN +: ELEN] = full[W2-1:ELEN];
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = !(cyc >= win_lo && cyc <= win_hi);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic [VLEN-1:0] elo;
        logic [VLEN-1:0] ehi;
        if (reset) begin
            sb.delete();
            for (int i = 0; i < NL; i++) macc[i] = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_lo", res_lo, prev_lo);
                check("hold_hi", res_hi, prev_hi);
            end
            if (bp_chk) begin
                check("in_ready", in_ready, !(out_valid && !out_ready));
                if (out_valid && !out_ready) stall_seen++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("res_lo", res_lo, e.lo);
                    check("res_hi", res_hi, e.hi);
                    if (lat_chk) check("latency", cyc - e.t, LAT);
                    log_lo.push_back(res_lo);
                    log_hi.push_back(res_hi);
                    log_t.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                model(op, acc_clr, a, b, elo, ehi);
                e.lo = elo;
                e.hi = ehi;
                e.t  = cyc;
                sb.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_lo    = res_lo;
            prev_hi    = res_hi;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high on return; the caller either sends again or idles.
    task automatic send(input logic [1:0] s_op, input logic s_clr,
                        input logic [VLEN-1:0] s_a, input logic [VLEN-1:0] s_b);
        int   k;
        logic ok;
        k  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        op       = s_op;
        acc_clr  = s_clr;
        a        = s_a;
        b        = s_b;
        while (!ok && k < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) check("send_accept", ok, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && k < 5000) begin
            step(1);
            k++;
        end
        check("drain_empty", sb.size(), 0);
        step(2);
    endtask

    task automatic clear_log();
        log_lo.delete();
        log_hi.delete();
        log_t.delete();
    endtask

    initial begin
        logic [VLEN-1:0] va;
        logic [VLEN-1:0] vb;
        logic [VLEN-1:0] elo;
        logic [VLEN-1:0] ehi;
        logic [ELEN-1:0] lane_ones;

        lane_ones = '1;

        // Reset state
        step(3);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_res_lo", res_lo, '0);
        check("rst_res_hi", res_hi, '0);

        // ADD carry / SUB borrow
        lat_chk = 1'b1;
        clear_log();
        send(OP_ADD, 1'b0, '1, rep(ELEN'(1)));
        send(OP_SUB, 1'b0, '0, rep(ELEN'(1)));
        drain();
        check("addsub_count", log_lo.size(), 2);
        check("add_lo", log_lo[0], '0);
        check("add_hi", log_hi[0], rep(ELEN'(1)));
        check("sub_lo", log_lo[1], '1);
        check("sub_hi", log_hi[1], rep(ELEN'(1)));

        // MUL full product
        clear_log();
        va = '0;
        vb = '0;
        va[ELEN-1:0]    = lane_ones;
        vb[ELEN-1:0]    = lane_ones;
        va[ELEN +: ELEN] = ELEN'(3);
        vb[ELEN +: ELEN] = ELEN'(5);
        elo = '0;
        ehi = '0;
        elo[ELEN-1:0]     = ELEN'(1);
        elo[ELEN +: ELEN] = ELEN'(15);
        ehi[ELEN-1:0]     = lane_ones - ELEN'(1);
        send(OP_MUL, 1'b0, va, vb);
        drain();
        check("mul_count", log_lo.size(), 1);
        check("mul_lo", log_lo[0], elo);
        check("mul_hi", log_hi[0], ehi);

        // MAC chain back-to-back
        clear_log();
        send(OP_MAC, 1'b1, rep(ELEN'(2)), rep(ELEN'(3)));
        send(OP_MAC, 1'b0, rep(ELEN'(4)), rep(ELEN'(5)));
        send(OP_MAC, 1'b0, rep(ELEN'(1)), rep(ELEN'(1)));
        drain();
        check("mac_count", log_lo.size(), 3);
        check("mac0", log_lo[0], rep(ELEN'(6)));
        check("mac1", log_lo[1], rep(ELEN'(26)));
        check("mac2", log_lo[2], rep(ELEN'(27)));
        check("mac_hi", log_hi[2], '0);
        check("mac_consecutive", log_t[2] - log_t[0], 2);

        // Reset mid-stream: accumulator is nonzero (27) going in
        send(OP_ADD, 1'b0, rep(ELEN'(7)), rep(ELEN'(1)));
        send(OP_ADD, 1'b0, rep(ELEN'(8)), rep(ELEN'(1)));
        send(OP_ADD, 1'b0, rep(ELEN'(9)), rep(ELEN'(1)));
        in_valid = 1'b0;
        reset    = 1'b1;
        step(1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_out_valid", out_valid, 1'b0);
            check("post_rst_in_ready", in_ready, 1'b1);
            step(1);
        end
        clear_log();
        send(OP_MAC, 1'b0, rep(ELEN'(1)), rep(ELEN'(1)));
        drain();
        check("post_rst_mac_count", log_lo.size(), 1);
        check("post_rst_mac_lo", log_lo[0], rep(ELEN'(1)));
        check("post_rst_mac_hi", log_hi[0], '0);

        // Backpressure: consumer stalls cycles 4..7 of the stream
        lat_chk    = 1'b0;
        bp_chk     = 1'b1;
        stall_seen = 0;
        clear_log();
        win_lo   = cyc + 4;
        win_hi   = cyc + 7;
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            send(OP_ADD, 1'b0, rep(ELEN'(k)), rep(ELEN'(100)));
        end
        drain();
        rdy_mode = 0;
        bp_chk   = 1'b0;
        check("bp_count", log_lo.size(), 8);
        check("bp_stall_seen", stall_seen > 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("bp_order", log_lo[k], rep(ELEN'(k + 100)));
        end

        // Random traffic with random in_valid gaps and out_ready
        rdy_mode = 2;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step($urandom_range(1, 2));
            end
            send(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), rnd_vec(), rnd_vec());
        end
        drain();
        rdy_mode = 0;
        step(5);
        check("idle_out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #2000000;
        check("global_timeout", 1'b1, 1'b0 + {1'b0, (cyc < 0)});
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_vector_alu_pipe
`default_nettype wire
